// File: rtl/serial_link_vc_credit_sync_pkg.sv
// Shared defaults and width helpers for the serial-link VC credit unit.
// Credit and VC widths depend on parameters, so only helpers live here.
package serial_link_vc_credit_sync_pkg;

    localparam int unsigned DefNumVc      = 2;
    localparam int unsigned DefDataWidth  = 64;
    localparam int unsigned DefNumCredits = 8;

    function automatic int unsigned cred_width(input int unsigned num_credits);
        return unsigned'($clog2(num_credits + 1));
    endfunction

    function automatic int unsigned vc_width(input int unsigned num_vc);
        return (num_vc > 1) ? unsigned'($clog2(num_vc)) : 1;
    endfunction

endpackage

// File: rtl/serial_link_vc_credit_sync_counter.sv
// Per-VC credit bookkeeping: available (far-side) credits and credits owed back.
// Also decides data eligibility, including the last-credit deadlock rule.
module serial_link_vc_credit_counter
    import serial_link_vc_credit_sync_pkg::*;
#(
    parameter int unsigned  NumCredits = DefNumCredits,
    localparam int unsigned CredW      = cred_width(NumCredits),
    localparam int unsigned WideW      = CredW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             send_valid_i,
    input  logic             cred_pending_i,
    output logic             eligible_o,
    input  logic             grant_i,
    input  logic             cred_take_i,
    input  logic             buf_pop_i,
    input  logic             rx_cred_i,
    input  logic [CredW-1:0] rx_credits_i,
    output logic [CredW-1:0] avail_o,
    output logic [CredW-1:0] tosend_o
);

    logic [CredW-1:0] avail_q, avail_d, tosend_q, tosend_d;
    logic [WideW-1:0] avail_wide_c, tosend_wide_c;

    // The last credit may only be spent on a packet that also returns credits.
    assign eligible_o = send_valid_i &&
                        ((avail_q > CredW'(1)) || ((avail_q == CredW'(1)) && cred_pending_i));

    always_comb begin
        avail_wide_c  = WideW'(avail_q)
                      + (rx_cred_i ? WideW'(rx_credits_i) : '0)
                      - WideW'(grant_i);
        tosend_wide_c = WideW'(cred_take_i ? '0 : tosend_q) + WideW'(buf_pop_i);
        avail_d       = avail_wide_c[CredW-1:0];
        tosend_d      = tosend_wide_c[CredW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avail_q  <= CredW'(NumCredits);
            tosend_q <= '0;
        end else begin
            avail_q  <= avail_d;
            tosend_q <= tosend_d;
        end
    end

    assign avail_o  = avail_q;
    assign tosend_o = tosend_q;

    a_avail_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        avail_wide_c <= WideW'(NumCredits));
    a_tosend_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        tosend_wide_c <= WideW'(NumCredits));

endmodule

// File: rtl/serial_link_vc_credit_sync.sv
// Multi-VC credit flow control: round-robin data arbitration onto one registered
// link stage, piggybacked credit return, and forced credit-only packets.
module serial_link_vc_credit_sync
    import serial_link_vc_credit_sync_pkg::*;
#(
    parameter int unsigned  NumVc           = DefNumVc,
    parameter int unsigned  DataWidth       = DefDataWidth,
    parameter int unsigned  NumCredits      = DefNumCredits,
    parameter int unsigned  ForceSendThresh = NumCredits - 4,
    localparam int unsigned CredW           = cred_width(NumCredits),
    localparam int unsigned VcW             = vc_width(NumVc)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumVc-1:0]           send_valid_i,
    output logic [NumVc-1:0]           send_ready_o,
    input  logic [NumVc*DataWidth-1:0] send_data_i,
    output logic                       link_valid_o,
    input  logic                       link_ready_i,
    output logic [DataWidth-1:0]       link_data_o,
    output logic [VcW-1:0]             link_vc_o,
    output logic                       link_cred_only_o,
    output logic [VcW-1:0]             link_cred_vc_o,
    output logic [CredW-1:0]           link_credits_o,
    input  logic                       rx_cred_valid_i,
    input  logic [VcW-1:0]             rx_cred_vc_i,
    input  logic [CredW-1:0]           rx_credits_i,
    input  logic [NumVc-1:0]           buf_pop_i,
    output logic [NumVc*CredW-1:0]     credits_available_o
);

    logic [NumVc-1:0][CredW-1:0] avail, tosend;
    logic [NumVc-1:0]            eligible;
    logic [VcW-1:0]              cred_vc_c, grant_vc_c, vc_hi_c, vc_lo_c;
    logic [CredW-1:0]            cred_max_c;
    logic                        found_hi_c, any_elig_c;
    logic                        loadable_c, load_data_c, load_force_c, load_c;
    logic [DataWidth-1:0]        grant_data_c;

    logic                        link_valid_q, link_valid_d;
    logic [DataWidth-1:0]        link_data_q, link_data_d;
    logic [VcW-1:0]              link_vc_q, link_vc_d;
    logic                        link_cred_only_q, link_cred_only_d;
    logic [VcW-1:0]              link_cred_vc_q, link_cred_vc_d;
    logic [CredW-1:0]            link_credits_q, link_credits_d;
    logic [VcW-1:0]              rr_q, rr_d;

    for (genvar v = 0; v < NumVc; v++) begin : g_vc
        serial_link_vc_credit_counter #(.NumCredits(NumCredits)) u_counter (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .send_valid_i   (send_valid_i[v]),
            .cred_pending_i (cred_max_c != '0),
            .eligible_o     (eligible[v]),
            .grant_i        (send_ready_o[v]),
            .cred_take_i    (load_c && (cred_vc_c == VcW'(v))),
            .buf_pop_i      (buf_pop_i[v]),
            .rx_cred_i      (rx_cred_valid_i && (rx_cred_vc_i == VcW'(v))),
            .rx_credits_i   (rx_credits_i),
            .avail_o        (avail[v]),
            .tosend_o       (tosend[v])
        );
        assign credits_available_o[v*CredW +: CredW] = avail[v];
    end

    // Credit VC: largest owed count, lowest index on ties.
    always_comb begin
        cred_vc_c  = '0;
        cred_max_c = tosend[0];
        for (int unsigned v = 1; v < NumVc; v++) begin
            if (tosend[v] > cred_max_c) begin
                cred_max_c = tosend[v];
                cred_vc_c  = VcW'(v);
            end
        end
    end

    // Round-robin: first eligible at or above rr_q, else first eligible overall.
    always_comb begin
        found_hi_c = 1'b0;
        any_elig_c = 1'b0;
        vc_hi_c    = '0;
        vc_lo_c    = '0;
        for (int unsigned v = 0; v < NumVc; v++) begin
            if (eligible[v] && !found_hi_c && (v >= 32'(rr_q))) begin
                found_hi_c = 1'b1;
                vc_hi_c    = VcW'(v);
            end
            if (eligible[v] && !any_elig_c) begin
                any_elig_c = 1'b1;
                vc_lo_c    = VcW'(v);
            end
        end
        grant_vc_c = found_hi_c ? vc_hi_c : vc_lo_c;
    end

    always_comb begin
        grant_data_c = '0;
        for (int unsigned v = 0; v < NumVc; v++) begin
            if (grant_vc_c == VcW'(v)) grant_data_c = send_data_i[v*DataWidth +: DataWidth];
        end
    end

    assign loadable_c   = !link_valid_q || link_ready_i;
    assign load_data_c  = loadable_c && any_elig_c;
    assign load_force_c = loadable_c && !any_elig_c && (32'(cred_max_c) >= ForceSendThresh);
    assign load_c       = load_data_c || load_force_c;
    assign send_ready_o = load_data_c ? (NumVc'(1) << grant_vc_c) : '0;

    always_comb begin
        link_valid_d     = link_valid_q;
        link_data_d      = link_data_q;
        link_vc_d        = link_vc_q;
        link_cred_only_d = link_cred_only_q;
        link_cred_vc_d   = link_cred_vc_q;
        link_credits_d   = link_credits_q;
        rr_d             = rr_q;
        if (load_c) begin
            link_valid_d     = 1'b1;
            link_data_d      = load_data_c ? grant_data_c : '0;
            link_vc_d        = load_data_c ? grant_vc_c : '0;
            link_cred_only_d = load_force_c;
            link_cred_vc_d   = cred_vc_c;
            link_credits_d   = cred_max_c;
            if (load_data_c) begin
                rr_d = (grant_vc_c == VcW'(NumVc - 1)) ? '0 : grant_vc_c + VcW'(1);
            end
        end else if (link_ready_i) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            link_valid_q     <= 1'b0;
            link_data_q      <= '0;
            link_vc_q        <= '0;
            link_cred_only_q <= 1'b0;
            link_cred_vc_q   <= '0;
            link_credits_q   <= '0;
            rr_q             <= '0;
        end else begin
            link_valid_q     <= link_valid_d;
            link_data_q      <= link_data_d;
            link_vc_q        <= link_vc_d;
            link_cred_only_q <= link_cred_only_d;
            link_cred_vc_q   <= link_cred_vc_d;
            link_credits_q   <= link_credits_d;
            rr_q             <= rr_d;
        end
    end

    assign link_valid_o     = link_valid_q;
    assign link_data_o      = link_data_q;
    assign link_vc_o        = link_vc_q;
    assign link_cred_only_o = link_cred_only_q;
    assign link_cred_vc_o   = link_cred_vc_q;
    assign link_credits_o   = link_credits_q;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(send_ready_o));
    a_rx_vc_range: assert property (@(posedge clk_i) disable iff (rst_i)
        !rx_cred_valid_i || (32'(rx_cred_vc_i) < NumVc));

endmodule

// File: tb/tb_serial_link_vc_credit_sync.sv
// Bench for serial_link_vc_credit_sync: directed scenarios, then random traffic,
// all checked against a cycle-level behavioural model of the credit rules.
module tb_serial_link_vc_credit_sync;

    localparam int NV  = 2;
    localparam int DW  = 64;
    localparam int NC  = 8;
    localparam int THR = NC - 4;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NV-1:0]   send_valid = '0;
    logic [NV-1:0]   send_ready;
    logic [NV*DW-1:0] send_data = '0;
    logic            link_valid;
    logic            link_ready = 1'b1;
    logic [DW-1:0]   link_data;
    logic [0:0]      link_vc;
    logic            link_cred_only;
    logic [0:0]      link_cred_vc;
    logic [CW-1:0]   link_credits;
    logic            rx_valid = 1'b0;
    logic [0:0]      rx_vc = '0;
    logic [CW-1:0]   rx_credits = '0;
    logic [NV-1:0]   buf_pop = '0;
    logic [NV*CW-1:0] credits_available;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_avail [NV];
    int          m_tosend[NV];
    int          m_rr;
    bit          m_valid;
    logic [DW-1:0] m_data;
    int          m_vc, m_cvc, m_cred;
    bit          m_co;

    always #5 clk = ~clk;

    serial_link_vc_credit_sync dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .send_valid_i        (send_valid),
        .send_ready_o        (send_ready),
        .send_data_i         (send_data),
        .link_valid_o        (link_valid),
        .link_ready_i        (link_ready),
        .link_data_o         (link_data),
        .link_vc_o           (link_vc),
        .link_cred_only_o    (link_cred_only),
        .link_cred_vc_o      (link_cred_vc),
        .link_credits_o      (link_credits),
        .rx_cred_valid_i     (rx_valid),
        .rx_cred_vc_i        (rx_vc),
        .rx_credits_i        (rx_credits),
        .buf_pop_i           (buf_pop),
        .credits_available_o (credits_available)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_avail[v]  = NC;
            m_tosend[v] = 0;
        end
        m_rr = 0; m_valid = 0; m_data = '0;
        m_vc = 0; m_cvc = 0; m_cred = 0; m_co = 0;
    endtask

    function automatic int avail_of(input int v);
        logic [NV*CW-1:0] ca;
        ca = credits_available;
        return int'(ca[v*CW +: CW]);
    endfunction

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic cyc();
        int cv, g, snap;
        bit loadable, ld_data, ld_force;
        logic [NV-1:0] exp_rdy;
        @(negedge clk);
        cv = 0;
        for (int v = 1; v < NV; v++) if (m_tosend[v] > m_tosend[cv]) cv = v;
        snap = m_tosend[cv];
        loadable = !m_valid || link_ready;
        g = -1;
        for (int k = 0; k < NV; k++) begin
            int v;
            v = (m_rr + k) % NV;
            if (g < 0 && send_valid[v] &&
                (m_avail[v] > 1 || (m_avail[v] == 1 && snap > 0))) g = v;
        end
        ld_data  = loadable && (g >= 0);
        ld_force = loadable && (g < 0) && (snap >= THR);
        exp_rdy  = ld_data ? NV'(1) << g : '0;
        chk("send_ready", 64'(send_ready), 64'(exp_rdy));
        chk("link_valid", 64'(link_valid), 64'(m_valid));
        if (m_valid) begin
            chk("link_data", link_data, m_data);
            chk("link_vc", 64'(link_vc), 64'(m_vc));
            chk("link_cred_only", 64'(link_cred_only), 64'(m_co));
            chk("link_cred_vc", 64'(link_cred_vc), 64'(m_cvc));
            chk("link_credits", 64'(link_credits), 64'(m_cred));
        end
        for (int v = 0; v < NV; v++) chk("credits_available", 64'(avail_of(v)), 64'(m_avail[v]));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int v = 0; v < NV; v++) begin
                m_tosend[v] += int'(buf_pop[v]);
                if ((ld_data || ld_force) && v == cv) m_tosend[v] -= snap;
                if (rx_valid && int'(rx_vc) == v) m_avail[v] += int'(rx_credits);
                if (ld_data && v == g) m_avail[v] -= 1;
            end
            if (ld_data || ld_force) begin
                m_valid = 1;
                m_data  = ld_data ? send_data[g*DW +: DW] : '0;
                m_vc    = ld_data ? g : 0;
                m_co    = ld_force;
                m_cvc   = cv;
                m_cred  = snap;
                if (ld_data) m_rr = (g + 1) % NV;
            end else if (m_valid && link_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic rand_data();
        for (int v = 0; v < NV; v++) send_data[v*DW +: DW] = {$urandom, $urandom};
    endtask

    initial begin
        int cnt, prev;
        int vcs[4];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        chk("rst_link_valid", 64'(link_valid), 64'd0);
        chk("rst_send_ready", 64'(send_ready), 64'd0);
        chk("rst_link_data", link_data, 64'd0);
        chk("rst_link_credits", 64'(link_credits), 64'd0);
        chk("rst_avail0", 64'(avail_of(0)), 64'(NC));
        chk("rst_avail1", 64'(avail_of(1)), 64'(NC));

        // Credit exhaustion on VC0
        send_valid = 2'b01;
        link_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            cyc();
            if (link_valid) cnt++;
        end
        chk("exhaust_pkt_count", 64'(cnt), 64'd7);
        chk("exhaust_avail0", 64'(avail_of(0)), 64'd1);

        // Last credit spent only with a returned credit
        buf_pop = 2'b01;
        cyc();
        buf_pop = 2'b00;
        rand_data();
        cyc();
        chk("last_valid", 64'(link_valid), 64'd1);
        chk("last_credits", 64'(link_credits), 64'd1);
        chk("last_cred_vc", 64'(link_cred_vc), 64'd0);
        chk("last_avail0", 64'(avail_of(0)), 64'd0);

        // Forced credit-only packet
        send_valid = 2'b00;
        buf_pop = 2'b10;
        repeat (4) cyc();
        buf_pop = 2'b00;
        cyc();
        chk("force_valid", 64'(link_valid), 64'd1);
        chk("force_cred_only", 64'(link_cred_only), 64'd1);
        chk("force_cred_vc", 64'(link_cred_vc), 64'd1);
        chk("force_credits", 64'(link_credits), 64'd4);
        chk("force_data", link_data, 64'd0);
        chk("force_avail0", 64'(avail_of(0)), 64'd0);
        chk("force_avail1", 64'(avail_of(1)), 64'(NC));

        // Refill VC0, park the pointer at VC0, then round-robin
        rx_valid = 1'b1; rx_vc = 1'b0; rx_credits = CW'(NC);
        cyc();
        rx_valid = 1'b0;
        send_valid = 2'b10;
        rand_data();
        cyc();
        send_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cyc();
            vcs[i] = int'(link_vc);
        end
        for (int i = 0; i < 4; i++) chk("rr_vc", 64'(vcs[i]), 64'(i % 2));

        // Stall with pops on VC0
        link_ready = 1'b0;
        send_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            buf_pop = (i < 3) ? 2'b01 : 2'b00;
            rand_data();
            cyc();
        end
        buf_pop = 2'b00;
        chk("stall_held_vc", 64'(link_vc), 64'd1);
        link_ready = 1'b1;
        cyc();
        chk("stall_release_credits", 64'(link_credits), 64'd3);
        chk("stall_release_cred_vc", 64'(link_cred_vc), 64'd0);
        chk("stall_release_vc", 64'(link_vc), 64'd0);

        // Rx credit and grant in the same cycle
        prev = m_avail[0];
        rx_valid = 1'b1; rx_vc = 1'b0; rx_credits = CW'(2);
        rand_data();
        cyc();
        rx_valid = 1'b0;
        chk("simul_avail0", 64'(avail_of(0)), 64'(prev + 1));

        // Reset during a stall
        link_ready = 1'b0;
        buf_pop = 2'b01;
        repeat (2) cyc();
        buf_pop = 2'b00;
        send_valid = 2'b00;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_link_valid", 64'(link_valid), 64'd0);
        chk("rst2_avail0", 64'(avail_of(0)), 64'(NC));
        chk("rst2_avail1", 64'(avail_of(1)), 64'(NC));
        chk("rst2_link_credits", 64'(link_credits), 64'd0);
        link_ready = 1'b1;
        send_valid = 2'b01;
        rand_data();
        cyc();
        chk("rst2_first_credits", 64'(link_credits), 64'd0);
        chk("rst2_first_vc", 64'(link_vc), 64'd0);

        // Random traffic within the credit invariants
        for (int i = 0; i < 400; i++) begin
            int rv;
            send_valid = NV'($urandom_range(0, 3));
            link_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            for (int v = 0; v < NV; v++)
                buf_pop[v] = (m_tosend[v] < NC) && ($urandom_range(0, 3) == 0);
            rv = $urandom_range(0, NV - 1);
            rx_vc = rv[0:0];
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_credits = CW'($urandom_range(0, NC - m_avail[rv]));
            cyc();
        end
        send_valid = '0; buf_pop = '0; rx_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
